// File: rtl/tx_pkg.sv
// Shared transmit-path types and constants.
// Holds the tone sequencer state enum, table address width and table read latency.
package tx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      TONE = 1'b1
   } state_t;

   localparam int TBL_ADDR_W = 8;
   localparam int TBL_LAT    = 1;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator for the FSK tone sequencer.
// Ports: clk, rst_n (sync, active-low), load (latch ftw_new), step (advance),
//        ftw_new (tuning word to latch), addr (top 8 phase bits).
// CONT_PHASE_EN: when defined, a load keeps the running phase instead of clearing it.
import tx_pkg::*;

module phase_acc #(
   parameter int ACC_W = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  step,
   input  logic [ACC_W-1:0]      ftw_new,
   output logic [TBL_ADDR_W-1:0] addr
);

   logic [ACC_W-1:0] phase_q;
   logic [ACC_W-1:0] ftw_q;

   // The step uses the old ftw; a same-cycle load only affects later samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q <= '0;
         ftw_q   <= '0;
      end else begin
         if (step)
            phase_q <= phase_q + ftw_q;
`ifndef CONT_PHASE_EN
         if (load)
            phase_q <= '0;
`endif
         if (load)
            ftw_q <= ftw_new;
      end
   end

   assign addr = phase_q[ACC_W-1 -: TBL_ADDR_W];

endmodule

// File: rtl/fsk_tone_seq.sv
// Binary-FSK tone sequencer feeding a registered sine/cosine table.
// Ports: clk, rst_n (sync, active-low), en (sample strobe), sym_valid/sym_ready/sym_bit
//        (symbol handshake), ftw_mark/ftw_space (tuning words), tbl_addr, tbl_valid, busy.
// CONT_PHASE_EN: when defined, phase runs continuously across symbols (CP-FSK).
import tx_pkg::*;

module fsk_tone_seq #(
   parameter int ACC_W   = 24,
   parameter int SYM_LEN = 64,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  sym_valid,
   output logic                  sym_ready,
   input  logic                  sym_bit,
   input  logic [ACC_W-1:0]      ftw_mark,
   input  logic [ACC_W-1:0]      ftw_space,
   output logic [TBL_ADDR_W-1:0] tbl_addr,
   output logic                  tbl_valid,
   output logic                  busy
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_LEN - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    last;
   logic                    step;
   logic                    accept;
   logic                    addr_stb;
   logic [TBL_ADDR_W-1:0]   phase_addr;
   logic [TBL_LAT-1:0]      vld_sr;

   always_comb begin
      state_d   = state_q;
      sym_ready = 1'b0;
      last      = (cnt_q == LAST);
      step      = (state_q == TONE) && en;
      unique case (state_q)
         IDLE: sym_ready = 1'b1;
         TONE: begin
            sym_ready = en && last;
            if (step && last)
               state_d = IDLE;
         end
      endcase
      accept = sym_valid && sym_ready;
      if (accept)
         state_d = TONE;
      cnt_d = cnt_q;
      if (accept)
         cnt_d = '0;
      else if (step)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_stb <= 1'b0;
         tbl_addr <= '0;
         vld_sr   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_stb <= step;
         if (step)
            tbl_addr <= phase_addr;
         // Delay the address strobe by the table read latency.
         vld_sr[0] <= addr_stb;
         for (int i = 1; i < TBL_LAT; i++)
            vld_sr[i] <= vld_sr[i-1];
      end
   end

   phase_acc #(
      .ACC_W (ACC_W)
   ) u_phase_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .step    (step),
      .ftw_new (sym_bit ? ftw_mark : ftw_space),
      .addr    (phase_addr)
   );

   assign tbl_valid = vld_sr[TBL_LAT-1];
   assign busy      = (state_q == TONE);

endmodule

// File: tb/tb_fsk_tone_seq.sv
// Self-checking bench for fsk_tone_seq with a symbol-level reference model.
// Honours CONT_PHASE_EN the same way as the design build.
module tb_fsk_tone_seq;

   localparam int ACC_W   = 24;
   localparam int SYM_LEN = 4;
   localparam int CNT_W   = 16;
   localparam logic [23:0] MARK  = 24'h040000;
   localparam logic [23:0] SPACE = 24'h100000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        sym_valid = 1'b0;
   logic        sym_bit = 1'b0;
   logic [23:0] ftw_mark = MARK;
   logic [23:0] ftw_space = SPACE;
   logic        sym_ready;
   logic [7:0]  tbl_addr;
   logic        tbl_valid;
   logic        busy;

   int vectors = 0;
   int errors  = 0;

   // Reference model: samples left in the symbol, running phase, tone word.
   int          m_rem   = 0;
   logic [23:0] m_phase = '0;
   logic [23:0] m_ftw   = '0;
   logic [7:0]  m_addr  = '0;
   logic        m_issued = 1'b0;
   logic        m_valid  = 1'b0;
   logic        m_acc    = 1'b0;

   always #5 clk = ~clk;

   fsk_tone_seq #(
      .ACC_W   (ACC_W),
      .SYM_LEN (SYM_LEN),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_bit   (sym_bit),
      .ftw_mark  (ftw_mark),
      .ftw_space (ftw_space),
      .tbl_addr  (tbl_addr),
      .tbl_valid (tbl_valid),
      .busy      (busy)
   );

   // One clock: drive at negedge, check handshake, advance model at posedge, check outputs.
   task automatic cycle(input logic e, input logic v, input logic b);
      logic r;
      @(negedge clk);
      en = e; sym_valid = v; sym_bit = b;
      #1;
      r = (m_rem == 0) || (m_rem == 1 && e);
      vectors++;
      if (sym_ready !== r) begin
         errors++;
         $display("FAIL sym_ready got %b exp %b t=%0t", sym_ready, r, $time);
      end
      m_acc = v && r && rst_n;
      @(posedge clk);
      m_valid  = m_issued;
      m_issued = 1'b0;
      if (!rst_n) begin
         m_rem = 0; m_phase = '0; m_ftw = '0; m_addr = '0;
         m_valid = 1'b0;
      end else begin
         if (m_rem > 0 && e) begin
            m_addr   = m_phase[23:16];
            m_issued = 1'b1;
            m_phase  = m_phase + m_ftw;
            m_rem--;
         end
         if (m_acc) begin
            m_ftw = b ? ftw_mark : ftw_space;
            m_rem = SYM_LEN;
`ifndef CONT_PHASE_EN
            m_phase = '0;
`endif
         end
      end
      #1;
      vectors++;
      if (tbl_addr !== m_addr) begin
         errors++;
         $display("FAIL tbl_addr got %h exp %h t=%0t", tbl_addr, m_addr, $time);
      end
      vectors++;
      if (tbl_valid !== m_valid) begin
         errors++;
         $display("FAIL tbl_valid got %b exp %b t=%0t", tbl_valid, m_valid, $time);
      end
      vectors++;
      if (busy !== (m_rem > 0)) begin
         errors++;
         $display("FAIL busy got %b exp %b t=%0t", busy, (m_rem > 0), $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (tbl_addr !== 8'h00) begin
         errors++; $display("FAIL reset_addr got %h exp 00", tbl_addr);
      end
      vectors++;
      if (tbl_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b exp 0", tbl_valid);
      end
      vectors++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b exp 0", busy);
      end
      vectors++;
      if (sym_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", sym_ready);
      end
   endtask

   // Accept one mark symbol and compare its four addresses against a fixed list.
   task automatic run_mark(input string name, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] exp_a [4];
      logic [7:0] got [$];
      int nval;
      logic busy4;
      exp_a = '{e0, e1, e2, e3};
      nval = 0;
      busy4 = 1'b1;
      do_reset();
      cycle(1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= 5; k++) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (k <= 4) got.push_back(tbl_addr);
         if (tbl_valid === 1'b1 && k >= 2) nval++;
         if (k == 4) busy4 = busy;
      end
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (got[k] !== exp_a[k]) begin
            errors++;
            $display("FAIL %s addr%0d got %h exp %h", name, k, got[k], exp_a[k]);
         end
      end
      vectors++;
      if (nval != 4) begin
         errors++; $display("FAIL %s valid_count got %0d exp 4", name, nval);
      end
      vectors++;
      if (busy4 !== 1'b0) begin
         errors++; $display("FAIL %s busy_after_last got %b exp 0", name, busy4);
      end
   endtask

   task automatic test_single_mark();
      run_mark("single_mark", 8'h00, 8'h04, 8'h08, 8'h0C);
   endtask

   task automatic test_wrap();
      ftw_mark = 24'hC00000;
      run_mark("wrap", 8'h00, 8'hC0, 8'h80, 8'h40);
      ftw_mark = MARK;
   endtask

   task automatic test_back_to_back();
      logic [7:0] addrs [$];
      logic       vals [$];
      int         acc_edge;
      int         first, lastv;
      logic [7:0] sp [4];
`ifdef CONT_PHASE_EN
      sp = '{8'h10, 8'h20, 8'h30, 8'h40};
`else
      sp = '{8'h00, 8'h10, 8'h20, 8'h30};
`endif
      acc_edge = -1;
      do_reset();
      cycle(1'b1, 1'b1, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b1, acc_edge < 0, 1'b0);
         if (m_acc && acc_edge < 0) acc_edge = k;
         if (m_issued) addrs.push_back(tbl_addr);
         vals.push_back(tbl_valid);
      end
      vectors++;
      if (acc_edge != 4) begin
         errors++; $display("FAIL b2b accept_edge got %0d exp 4", acc_edge);
      end
      vectors++;
      if (addrs.size() != 8) begin
         errors++; $display("FAIL b2b addr_count got %0d exp 8", addrs.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (addrs[k+4] !== sp[k]) begin
               errors++;
               $display("FAIL b2b space%0d got %h exp %h", k, addrs[k+4], sp[k]);
            end
         end
      end
      first = -1; lastv = -1;
      foreach (vals[i]) if (vals[i] === 1'b1) begin
         if (first < 0) first = i;
         lastv = i;
      end
      vectors++;
      if (first != 1 || lastv != 8) begin
         errors++; $display("FAIL b2b valid_span got %0d..%0d exp 1..8", first, lastv);
      end
   endtask

   task automatic test_en_gap();
      int pulses, nbusy;
      logic prev;
      pulses = 0; nbusy = 0; prev = 1'b0;
      do_reset();
      cycle(1'b1, 1'b1, 1'b1);
      if (busy === 1'b1) nbusy++;
      for (int k = 1; k <= 10; k++) begin
         cycle((k % 2) == 0, 1'b0, 1'b0);
         if (busy === 1'b1) nbusy++;
         if (tbl_valid === 1'b1) begin
            pulses++;
            vectors++;
            if (prev === 1'b1) begin
               errors++; $display("FAIL en_gap adjacent_valid at k=%0d", k);
            end
         end
         prev = tbl_valid;
      end
      vectors++;
      if (pulses != 4) begin
         errors++; $display("FAIL en_gap pulses got %0d exp 4", pulses);
      end
      vectors++;
      if (nbusy != 8) begin
         errors++; $display("FAIL en_gap busy_cycles got %0d exp 8", nbusy);
      end
   endtask

   task automatic test_reset_mid();
      int nval;
      nval = 0;
      do_reset();
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      cycle(1'b1, 1'b0, 1'b0);
      rst_n = 1'b1;
      vectors++;
      if (tbl_addr !== 8'h00 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid state got addr=%h busy=%b exp 00/0", tbl_addr, busy);
      end
      repeat (3) begin
         cycle(1'b1, 1'b0, 1'b0);
         if (tbl_valid === 1'b1) nval++;
      end
      vectors++;
      if (nval != 0) begin
         errors++; $display("FAIL reset_mid stray_valid got %0d exp 0", nval);
      end
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      vectors++;
      if (tbl_addr !== 8'h00) begin
         errors++; $display("FAIL reset_mid restart_addr got %h exp 00", tbl_addr);
      end
      repeat (5) cycle(1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         ftw_mark  = 24'($urandom);
         ftw_space = 24'($urandom);
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, 1'($urandom));
      end
      ftw_mark = MARK;
      ftw_space = SPACE;
   endtask

   initial begin
      test_reset();
      test_single_mark();
      test_back_to_back();
      test_en_gap();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
